// File: rtl/ps2_key_ctrl_pkg.sv
// ps2_key_ctrl_pkg
//   Shared definitions for the PS/2 key controller: set-2 scan codes,
//   parser state encoding, held-map bit indices and the key decoder.
package ps2_key_ctrl_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Key codes (Up/Down only count when E0-prefixed)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;

  // The pause key sends E1 followed by seven more bytes that must be dropped
  localparam logic [2:0] PAUSE_SKIP_BYTES = 3'd7;

  // Held-map bit positions: {P,Space,Down,Up,S,W}
  localparam int unsigned K_W     = 0;
  localparam int unsigned K_S     = 1;
  localparam int unsigned K_UP    = 2;
  localparam int unsigned K_DOWN  = 3;
  localparam int unsigned K_SPACE = 4;
  localparam int unsigned K_P     = 5;
  localparam int unsigned N_KEYS  = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } parser_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Map a completed code (plus its E0 flag) onto a held-map bit.
  function automatic key_hit_t decode_key(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b0;
    r.idx = 3'd0;
    if (ext) begin
      if (code == SC_UP) begin
        r.hit = 1'b1; r.idx = 3'(K_UP);
      end else if (code == SC_DOWN) begin
        r.hit = 1'b1; r.idx = 3'(K_DOWN);
      end
    end else begin
      if (code == SC_W) begin
        r.hit = 1'b1; r.idx = 3'(K_W);
      end else if (code == SC_S) begin
        r.hit = 1'b1; r.idx = 3'(K_S);
      end else if (code == SC_SPACE) begin
        r.hit = 1'b1; r.idx = 3'(K_SPACE);
      end else if (code == SC_P) begin
        r.hit = 1'b1; r.idx = 3'(K_P);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// ps2_prefix_timer
//   Counts cycles while the parser waits for the rest of a multi-byte code.
//   Ports:
//     clk, rst  clock, synchronous active-high reset
//     clear     hold the count at zero (new byte, frame error, or parser idle)
//     expire    1-cycle strobe on the LIMIT-th uncleared cycle
module ps2_prefix_timer #(
  parameter int unsigned LIMIT = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CNT_W-1:0] cnt;

  assign expire = !clear && (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
//   Turns received PS/2 set-2 bytes into a held-key map and game controls.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     rx_valid     strobe: rx_byte holds a received byte
//     rx_byte      received scan byte
//     rx_err       strobe: frame error, byte dropped, parser restarts
//     game_tick    frame-rate strobe
//     p1_dy/p2_dy  signed paddle steps, registered on game_tick
//     dy_valid     strobe one cycle after game_tick
//     start_pulse  pulse on the first Space make
//     paused       pause level, toggled on the first P make
//     held         held map {P,Space,Down,Up,S,W}
//     dbg_state    current parser state
//   Handshake: all inputs are single-cycle strobes with no back-pressure;
//   a byte is consumed on the cycle rx_valid is high, and rx_err in the same
//   cycle overrides it. Outputs are strobes or levels, never held for ready.
module ps2_key_ctrl
  import ps2_key_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned SPEED      = 4,
  parameter int unsigned DY_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_err,
  input  logic                   game_tick,
  output logic signed [DY_W-1:0] p1_dy,
  output logic signed [DY_W-1:0] p2_dy,
  output logic                   dy_valid,
  output logic                   start_pulse,
  output logic                   paused,
  output logic [N_KEYS-1:0]      held,
  output logic [2:0]             dbg_state
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam logic signed [DY_W-1:0] STEP_POS = DY_W'(SPEED);
  localparam logic signed [DY_W-1:0] STEP_NEG = -STEP_POS;

  parser_state_t state, state_next;
  logic [2:0]    skip_cnt, skip_next;
  logic          key_make, key_brk, key_ext;
  logic          tmo_expire;
  key_hit_t      key;

  assign dbg_state = state;

  ps2_prefix_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid | rx_err | (state == ST_IDLE)),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // Priority: frame error, then a new byte, then the prefix timeout.
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    key_make   = 1'b0;
    key_brk    = 1'b0;
    key_ext    = 1'b0;
    if (rx_err) begin
      state_next = ST_IDLE;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_next = ST_EXT;
          end else if (rx_byte == SC_BRK) begin
            state_next = ST_BRK;
          end else if (rx_byte == SC_PAUSE) begin
            state_next = ST_SKIP;
            skip_next  = PAUSE_SKIP_BYTES;
          end else begin
            key_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) begin
            state_next = ST_EXT_BRK;
          end else begin
            key_make   = 1'b1;
            key_ext    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_brk    = 1'b1;
          state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          key_brk    = 1'b1;
          key_ext    = 1'b1;
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          skip_next = skip_cnt - 1'b1;
          if (skip_cnt == 3'd1) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      state_next = ST_IDLE;
    end
  end

  assign key = decode_key(rx_byte, key_ext);

  // Held map and edge actions. The edge checks use the held bit from before
  // this make, so typematic repeats do nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      held        <= '0;
      start_pulse <= 1'b0;
      paused      <= 1'b0;
    end else begin
      start_pulse <= key_make && key.hit && (key.idx == 3'(K_SPACE)) && !held[K_SPACE];
      if (key_make && key.hit && (key.idx == 3'(K_P)) && !held[K_P]) begin
        paused <= ~paused;
      end
      if (key.hit && key_make) begin
        held[key.idx] <= 1'b1;
      end else if (key.hit && key_brk) begin
        held[key.idx] <= 1'b0;
      end
    end
  end

  // Velocity samples held/paused as registered, i.e. before any byte that
  // lands on the same cycle as the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_dy    <= '0;
      p2_dy    <= '0;
      dy_valid <= 1'b0;
    end else begin
      dy_valid <= game_tick;
      if (game_tick) begin
        p1_dy <= '0;
        p2_dy <= '0;
        if (!paused) begin
          if (held[K_W] && !held[K_S]) p1_dy <= STEP_NEG;
          else if (held[K_S] && !held[K_W]) p1_dy <= STEP_POS;
          if (held[K_UP] && !held[K_DOWN]) p2_dy <= STEP_NEG;
          else if (held[K_DOWN] && !held[K_UP]) p2_dy <= STEP_POS;
        end
      end
    end
  end

endmodule
